mem_access_unit: RTL and testbench

- Load/store execution unit directly downstream of the multi-cycle control FSM; consumes its MEM-state controls (rd_en, wr_en, size, sign_ext) plus ALU address and rs2 data.
- Runs one request/acknowledge transaction per MEM phase against the word-wide data RAM.
- Performs byte-lane steering for stores and extraction/extension for loads.
- Returns a registered load word for WB and a one-cycle done pulse that lets the control FSM leave MEM.

---
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: one request/acknowledge RAM transaction per MEM phase, with byte-lane steering for stores and extension for loads.
// Optional LSU_TIMEOUT_EN adds a REQ wait counter, an ABORT state and the sticky timeout_err output.
module mem_access_unit
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
`ifdef LSU_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic [31:0] load_data,
    output logic        done,
    output logic        busy,
    output logic        misalign
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef LSU_TIMEOUT_EN
    localparam logic [1:0] S_ABORT = 2'd3;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_ext_q, sign_ext_d;
    logic        is_load_q, is_load_d;
    logic        we_q, we_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misalign_q, misalign_d;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    logic        bad_align;
    logic [3:0]  strb;
    logic [31:0] steered_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    // Alignment is judged on the live inputs so the decision is ready at the accepting edge.
    always_comb begin
        bad_align = 1'b0;
        case (size)
            2'b00:   bad_align = 1'b0;
            2'b01:   bad_align = addr[0];
            2'b10:   bad_align = (addr[1:0] != 2'b00);
            default: bad_align = 1'b1;
        endcase
    end

    always_comb begin
        strb          = 4'b1111;
        steered_wdata = wdata_q;
        case (size_q)
            2'b00: begin
                strb          = 4'b0001 << addr_q[1:0];
                steered_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb          = addr_q[1] ? 4'b1100 : 4'b0011;
                steered_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                strb          = 4'b1111;
                steered_wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'b00:   rd_byte = mem_rdata[7:0];
            2'b01:   rd_byte = mem_rdata[15:8];
            2'b10:   rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{sign_ext_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{sign_ext_q & rd_half[15]}}, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        sign_ext_d    = sign_ext_q;
        is_load_d     = is_load_q;
        we_d          = we_q;
        load_data_d   = load_data_q;
        misalign_d    = misalign_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    // A request with both enables set is treated as a store.
                    is_load_d  = rd_en & ~wr_en;
                    we_d       = wr_en;
                    misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d         = 8'd0;
                    timeout_err_d = 1'b0;
`endif
                    if (!(rd_en || wr_en)) begin
                        state_d = S_DONE;
                    end else if (bad_align) begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (is_load_q) begin
                        load_data_d = load_ext;
                    end
                    state_d = S_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef LSU_TIMEOUT_EN
            S_ABORT: begin
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            size_q        <= 2'd0;
            sign_ext_q    <= 1'b0;
            is_load_q     <= 1'b0;
            we_q          <= 1'b0;
            load_data_q   <= 32'd0;
            misalign_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            sign_ext_q    <= sign_ext_d;
            is_load_q     <= is_load_d;
            we_q          <= we_d;
            load_data_q   <= load_data_d;
            misalign_q    <= misalign_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // RAM-side outputs derive from state and latched operands, so they cannot move during a wait.
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wstrb = mem_we ? strb : 4'b0000;
    assign mem_wdata = steered_wdata;
    assign load_data = load_data_q;
    assign busy      = (state_q != S_IDLE);
    assign misalign  = misalign_q;
`ifdef LSU_TIMEOUT_EN
    assign done        = (state_q == S_DONE) || (state_q == S_ABORT);
    assign timeout_err = timeout_err_q;
`else
    assign done        = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected results are queued at stimulus time and checked when done pulses.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] load_data;
    logic        done;
    logic        busy;
    logic        misalign;
`ifdef LSU_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        access;
        logic [31:0] maddr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic [31:0] ld;
        logic        mis;
    } exp_t;

    exp_t sb[$];

`ifdef LSU_TIMEOUT_EN
    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
    mem_access_unit dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
`ifdef LSU_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .load_data (load_data),
        .done      (done),
        .busy      (busy),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic acc, input logic [31:0] ma, input logic we,
                                input logic [3:0] st, input logic [31:0] wd,
                                input logic [31:0] ld, input logic mis);
        exp_t e;
        e.access = acc;
        e.maddr  = ma;
        e.we     = we;
        e.strb   = st;
        e.mwdata = wd;
        e.ld     = ld;
        e.mis    = mis;
        return e;
    endfunction

    // One MEM phase: start at cycle 0, ack in cycle 1+dly, done expected in the following cycle.
    task automatic txn(input string name, input logic r, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly, input logic noise, input exp_t e);
        exp_t got;
        @(negedge clk);
        start = 1'b1; rd_en = r; wr_en = w; size = sz; sign_ext = sx;
        addr = a; wdata = wd; mem_rdata = rd;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'd0;
        if (e.access) begin
            for (int i = 0; i <= dly; i++) begin
                check({name, "_req"}, 32'(mem_req), 32'd1);
                check({name, "_maddr"}, mem_addr, e.maddr);
                check({name, "_we"}, 32'(mem_we), 32'(e.we));
                if (e.we) begin
                    check({name, "_strb"}, 32'(mem_wstrb), 32'(e.strb));
                    check({name, "_wdata"}, mem_wdata, e.mwdata);
                end
                check({name, "_nodone"}, 32'(done), 32'd0);
                if (noise && i == 0) begin
                    start = 1'b1; rd_en = 1'b1; size = 2'b10; addr = 32'h0000_0204;
                end else begin
                    start = 1'b0; rd_en = 1'b0;
                end
                mem_ack = (i == dly);
                @(negedge clk);
            end
            mem_ack = 1'b0; start = 1'b0; rd_en = 1'b0;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_req_off"}, 32'(mem_req), 32'd0);
        check({name, "_busy_done"}, 32'(busy), 32'd1);
        n_checks++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected one entry", name);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({name, "_load_data"}, load_data, got.ld);
            check({name, "_misalign"}, 32'(misalign), 32'(got.mis));
        end
        @(negedge clk);
        check({name, "_done_off"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_mis_held"}, 32'(misalign), 32'(e.mis));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load", load_data, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        txn("lw_100", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1,
            mk(1, 32'h100, 0, 4'b0, 32'h0, 32'hDEADBEEF, 0));
        txn("lb_sx", 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 1, 0,
            mk(1, 32'h100, 0, 4'b0, 32'h0, 32'hFFFFFF80, 0));
        txn("lbu", 1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 0, 0,
            mk(1, 32'h100, 0, 4'b0, 32'h0, 32'h00000080, 0));
        txn("sh_22", 0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 32'h0, 1, 0,
            mk(1, 32'h20, 1, 4'b1100, 32'hABCDABCD, 32'h00000080, 0));
        txn("lw_mis", 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 0, 0,
            mk(0, 32'h0, 0, 4'b0, 32'h0, 32'h00000080, 1));
        @(negedge clk);
        check("mis_idle_hold", 32'(misalign), 32'd1);
        txn("sb_01", 0, 1, 2'b00, 0, 32'h1, 32'h7777775A, 32'h0, 1, 0,
            mk(1, 32'h0, 1, 4'b0010, 32'h5A5A5A5A, 32'h00000080, 0));
        txn("lh_sx", 1, 0, 2'b01, 1, 32'h2, 32'h0, 32'h80017FFF, 0, 0,
            mk(1, 32'h0, 0, 4'b0, 32'h0, 32'hFFFF8001, 0));
        txn("lhu", 1, 0, 2'b01, 0, 32'h6, 32'h0, 32'hBEEF0000, 2, 0,
            mk(1, 32'h4, 0, 4'b0, 32'h0, 32'h0000BEEF, 0));
        txn("size11", 1, 0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 0, 0,
            mk(0, 32'h0, 0, 4'b0, 32'h0, 32'h0000BEEF, 1));
        txn("sh_odd", 0, 1, 2'b01, 0, 32'h43, 32'h0, 32'h0, 0, 0,
            mk(0, 32'h0, 0, 4'b0, 32'h0, 32'h0000BEEF, 1));
        txn("noacc", 0, 0, 2'b10, 0, 32'h50, 32'h0, 32'h0, 0, 0,
            mk(0, 32'h0, 0, 4'b0, 32'h0, 32'h0000BEEF, 0));
        txn("rdwr_sw", 1, 1, 2'b10, 1, 32'h40, 32'hCAFEF00D, 32'h11111111, 1, 0,
            mk(1, 32'h40, 1, 4'b1111, 32'hCAFEF00D, 32'h0000BEEF, 0));

        // Stray ack while idle must not start or finish anything.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_done", 32'(done), 32'd0);
        check("stray_ack_busy", 32'(busy), 32'd0);
        check("stray_ack_load", load_data, 32'h0000BEEF);

        // Reset asserted one cycle into REQ.
        @(negedge clk);
        start = 1'b1; rd_en = 1'b1; size = 2'b10; addr = 32'h300; mem_rdata = 32'h99999999;
        @(negedge clk);
        start = 1'b0; rd_en = 1'b0;
        check("rstmid_req_pre", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_req", 32'(mem_req), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_load", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstmid_ack_done", 32'(done), 32'd0);
        check("rstmid_ack_busy", 32'(busy), 32'd0);
        check("rstmid_ack_load", load_data, 32'd0);
        @(negedge clk);
        check("rstmid_ack_done2", 32'(done), 32'd0);

`ifdef LSU_TIMEOUT_EN
        txn("to_seed", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0BADF00D, 0, 0,
            mk(1, 32'h10, 0, 4'b0, 32'h0, 32'h0BADF00D, 0));
        @(negedge clk);
        start = 1'b1; rd_en = 1'b1; size = 2'b10; addr = 32'h20; mem_rdata = 32'h12345678;
        @(negedge clk);
        start = 1'b0; rd_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("to_req_wait", 32'(mem_req), 32'd1);
            check("to_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("to_done", 32'(done), 32'd1);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_req_off", 32'(mem_req), 32'd0);
        check("to_load", load_data, 32'h0BADF00D);
        @(negedge clk);
        check("to_done_off", 32'(done), 32'd0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        txn("to_clear", 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0,
            mk(0, 32'h0, 0, 4'b0, 32'h0, 32'h0BADF00D, 0));
        check("to_err_cleared", 32'(timeout_err), 32'd0);
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
